// File: rtl/muldiv_sequencer.sv
// Iterative RISC-V M-extension sequencer: shift-add multiply and restoring divide, one bit per cycle.
// Optional build macro MULDIV_EARLY_OUT_EN shortcuts zero-divisor divides and multiply-by-zero.
module muldiv_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  output logic            ready,
  input  logic [2:0]      funct3,
  input  logic            is_op32,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state_o
);
  localparam int W2 = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FINISH} state_t;

  // Handshake: a request transfers on a rising edge where valid && ready && !flush;
  // ready is high only in IDLE, and out_valid is a one-cycle strobe with no backpressure.

  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sgn);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = (i < 32) ? v[i] : (sgn & v[31]);
    return r;
  endfunction

  state_t          state_q;
  logic [5:0]      cnt_q;
  logic [2:0]      f3_q;
  logic            op32_q;
  logic [W2-1:0]   acc_q;
  logic [W2-1:0]   mcand_q;
  logic [XLEN-1:0] opb_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] dividend_q;
  logic            neg_q;
  logic            rneg_q;
  logic            dzero_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;

  logic            wide32, rs1_sgn, rs2_sgn, a_neg, b_neg;
  logic [XLEN-1:0] op_a, op_b, a_mag, b_mag;
  logic [5:0]      n_last;

  assign wide32  = (XLEN == 64) && is_op32;
  // MUL/MULH/MULHSU/DIV/REM treat rs1 as signed; MULHSU alone leaves rs2 unsigned.
  assign rs1_sgn = (funct3 != 3'd3) && (funct3 != 3'd5) && (funct3 != 3'd7);
  assign rs2_sgn = rs1_sgn && (funct3 != 3'd2);
  assign op_a    = wide32 ? ext32(rs1, rs1_sgn) : rs1;
  assign op_b    = wide32 ? ext32(rs2, rs2_sgn) : rs2;
  assign a_neg   = rs1_sgn & op_a[XLEN-1];
  assign b_neg   = rs2_sgn & op_b[XLEN-1];
  assign a_mag   = a_neg ? -op_a : op_a;
  assign b_mag   = b_neg ? -op_b : op_b;
  assign n_last  = ((XLEN == 32) || wide32) ? 6'd31 : 6'd63;

  logic [W2-1:0]   mul_acc_d, prod;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_rem_d, quo_fix, rem_fix, raw_res, result_d;

  always_comb begin
    mul_acc_d = opb_q[0] ? (acc_q + mcand_q) : acc_q;
    div_shift = {rem_q, quot_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_rem_d = div_ge ? (div_shift[XLEN-1:0] - opb_q) : div_shift[XLEN-1:0];
    prod      = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -quot_q : quot_q;
    rem_fix   = rneg_q ? -rem_q : rem_q;
    if (dzero_q) begin
      quo_fix = '1;
      rem_fix = dividend_q;
    end
    if (f3_q[2]) raw_res = f3_q[1] ? rem_fix : quo_fix;
    else         raw_res = (f3_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[W2-1:XLEN];
    result_d = op32_q ? ext32(raw_res, 1'b1) : raw_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      f3_q        <= '0;
      op32_q      <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      opb_q       <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      dividend_q  <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      dzero_q     <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid && !flush) begin
            f3_q       <= funct3;
            op32_q     <= wide32;
            cnt_q      <= n_last;
            acc_q      <= '0;
            mcand_q    <= {{XLEN{1'b0}}, a_mag};
            opb_q      <= b_mag;
            rem_q      <= '0;
            // A 32-bit dividend starts in the upper half so its MSB is shifted out first.
            quot_q     <= wide32 ? (a_mag << (XLEN / 2)) : a_mag;
            dividend_q <= op_a;
            neg_q      <= a_neg ^ b_neg;
            rneg_q     <= a_neg;
            dzero_q    <= (op_b == '0);
            state_q    <= funct3[2] ? S_DIV : S_MUL;
`ifdef MULDIV_EARLY_OUT_EN
            if (funct3[2] ? (op_b == '0) : ((op_a == '0) || (op_b == '0)))
              state_q <= S_FINISH;
`endif
          end
        end
        S_MUL: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            acc_q   <= mul_acc_d;
            mcand_q <= mcand_q << 1;
            opb_q   <= opb_q >> 1;
            cnt_q   <= cnt_q - 6'd1;
            if (cnt_q == 6'd0) state_q <= S_FINISH;
          end
        end
        S_DIV: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            rem_q  <= div_rem_d;
            quot_q <= {quot_q[XLEN-2:0], div_ge};
            cnt_q  <= cnt_q - 6'd1;
            if (cnt_q == 6'd0) state_q <= S_FINISH;
          end
        end
        default: begin
          if (!flush) begin
            out_valid_q <= 1'b1;
            result_q    <= result_d;
          end
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready       = (state_q == S_IDLE);
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer (XLEN=64): hand-computed results, latencies, flush and reset.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        rst, valid, ready, is_op32, flush, out_valid;
  logic [2:0]  funct3;
  logic [63:0] rs1, rs2, result;
  logic [1:0]  dbg_state;
  int          total = 0;
  int          bad   = 0;
  int          q;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 65;
`endif

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .ready      (ready),
    .funct3     (funct3),
    .is_op32    (is_op32),
    .rs1        (rs1),
    .rs2        (rs2),
    .flush      (flush),
    .out_valid  (out_valid),
    .result     (result),
    .dbg_state_o(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [2:0] f3, input logic op32,
                           input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    valid = 1'b1; funct3 = f3; is_op32 = op32; rs1 = a; rs2 = b;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  // Counts out_valid strobes over a fixed window.
  task automatic watch_quiet(input int cycles, output int strobes);
    strobes = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) strobes++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic op32,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat);
    int lat;
    check({tag, ".ready_before"}, 64'(ready), 64'd1);
    drive_req(f3, op32, a, b);
    check({tag, ".ready_busy"}, 64'(ready), 64'd0);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".result"}, result, exp);
    @(posedge clk);
    #1;
    check({tag, ".strobe_drop"}, 64'(out_valid), 64'd0);
    check({tag, ".result_held"}, result, exp);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; flush = 1'b0; funct3 = 3'd0; is_op32 = 1'b0;
    rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset.ready", 64'(ready), 64'd1);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.result", result, 64'd0);
    check("reset.state", 64'(dbg_state), 64'd0);

    run_op("mul_7_m3", 3'd0, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 65);
    run_op("mulhu_max", 3'd3, 1'b0, '1, '1, 64'hFFFFFFFFFFFFFFFE, 65);
    run_op("mulh_m1", 3'd1, 1'b0, '1, '1, 64'd0, 65);
    run_op("mulhsu_m1_2", 3'd2, 1'b0, '1, 64'd2, 64'hFFFFFFFFFFFFFFFF, 65);
    run_op("div_ovf", 3'd4, 1'b0, 64'h8000000000000000, '1, 64'h8000000000000000, 65);
    run_op("rem_ovf", 3'd6, 1'b0, 64'h8000000000000000, '1, 64'd0, 65);
    run_op("divu_zero", 3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, ZLAT);
    run_op("remu_zero", 3'd7, 1'b0, 64'd5, 64'd0, 64'd5, ZLAT);
    run_op("div_neg_zero", 3'd4, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd0, 64'hFFFFFFFFFFFFFFFF, ZLAT);
    run_op("rem_neg_zero", 3'd6, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd0, 64'hFFFFFFFFFFFFFFF9, ZLAT);
    run_op("divw_m7_2", 3'd4, 1'b1, 64'h00000000FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 33);
    run_op("remw_m7_2", 3'd6, 1'b1, 64'h00000000FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 33);
    run_op("mulw_hi_ignored", 3'd0, 1'b1, 64'hFFFFFFFF00000003, 64'd5, 64'd15, 33);
    run_op("mul_zero", 3'd0, 1'b0, 64'd0, 64'd12345, 64'd0, ZLAT);
    run_op("divu_100_7", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    run_op("remu_100_7", 3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65);
    run_op("rem_m7_2", 3'd6, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 65);

    // Flush ten cycles into a divide.
    drive_req(3'd5, 1'b0, 64'd1000, 64'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush.ready", 64'(ready), 64'd1);
    check("flush.state", 64'(dbg_state), 64'd0);
    watch_quiet(70, q);
    check("flush.no_strobe", 64'(q), 64'd0);
    run_op("after_flush_div", 3'd4, 1'b0, 64'hFFFFFFFFFFFFFF9C, 64'd7, 64'hFFFFFFFFFFFFFFF2, 65);

    // Flush wins over valid in IDLE.
    @(negedge clk);
    valid = 1'b1; flush = 1'b1; funct3 = 3'd0; is_op32 = 1'b0; rs1 = 64'd3; rs2 = 64'd3;
    @(posedge clk);
    #1;
    valid = 1'b0; flush = 1'b0;
    check("flush_prio.ready", 64'(ready), 64'd1);
    check("flush_prio.state", 64'(dbg_state), 64'd0);
    watch_quiet(70, q);
    check("flush_prio.no_strobe", 64'(q), 64'd0);

    // Reset in the middle of a multiply.
    drive_req(3'd0, 1'b0, 64'd7, 64'd9);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst.ready", 64'(ready), 64'd1);
    check("midrst.result", result, 64'd0);
    watch_quiet(70, q);
    check("midrst.no_strobe", 64'(q), 64'd0);
    run_op("after_rst_mul", 3'd0, 1'b0, 64'd7, 64'd9, 64'd63, 65);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width in bits (32 or 64).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port valid  input  1  request present; qualified by decoder is_muldiv.
REQ-005 SHALL have port ready  output  1  high only in IDLE; request accepted when valid and ready.
REQ-006 SHALL have port funct3  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have port is_op32  input  1  W-variant, legal only for funct3 0,4,5,6,7 when XLEN=64.
REQ-008 SHALL have port rs1  input  XLEN  first operand (multiplicand/dividend).
REQ-009 SHALL have port rs2  input  XLEN  second operand (multiplier/divisor).
REQ-010 SHALL have port flush  input  1  abort in-flight operation (pipeline redirect or trap).
REQ-011 SHALL have port out_valid  output  1  one-cycle strobe, result valid.
REQ-012 SHALL have port result  output  XLEN  operation result, held until next acceptance.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV, FINISH.
REQ-014 SHALL on acceptance latch funct3, is_op32 and operands; for op32, take low 32 bits of each operand, sign- or zero-extended per signedness.
REQ-015 SHALL go IDLE->MUL for funct3[2]=0 and IDLE->DIV for funct3[2]=1.
REQ-016 SHALL compute multiplication by iterative shift-add on operand magnitudes, one bit per cycle, with final sign correction.
REQ-017 SHALL compute division by iterative restoring division on magnitudes, one quotient bit per cycle; quotient sign = sign(rs1) xor sign(rs2), remainder sign = sign(rs1).
REQ-018 SHALL run N iterations, N=32 when is_op32 or XLEN=32, else N=64; counter counts N-1 down to 0, then FINISH.
REQ-019 SHALL in FINISH assert out_valid for exactly one cycle, then return to IDLE; out_valid rises N+1 cycles after the acceptance edge.
REQ-020 SHALL select result: MUL low XLEN bits; MULH/MULHSU/MULHU high XLEN bits of the 2*XLEN product; DIV/DIVU quotient; REM/REMU remainder.
REQ-021 SHALL, for op32, sign-extend bit 31 of the 32-bit result to XLEN.
REQ-022 SHALL, for divisor zero, return quotient all ones and remainder = dividend.
REQ-023 SHALL, for signed overflow (most-negative / -1), return quotient = dividend and remainder = 0.
REQ-024 SHALL on flush in MUL, DIV or FINISH return to IDLE next cycle without asserting out_valid.
REQ-025 SHALL give flush priority over valid when both are high in IDLE; the request is not accepted.
REQ-026 SHALL apply no output backpressure; the consumer stalls on ready=0 and samples result on out_valid.

Reset
REQ-027 SHALL on rst enter IDLE, clear counter, out_valid=0, result=0, ready=1 the following cycle.
REQ-028 SHALL on rst mid-operation abandon the operation and produce no out_valid.
REQ-029 SHALL give rst priority over flush and valid.

Configuration
REQ-030 SHALL honour macro MULDIV_EARLY_OUT_EN: when defined, a division with zero divisor goes IDLE->FINISH directly (out_valid 1 cycle after accept) and a multiplication by zero goes IDLE->FINISH with result 0; when undefined, all operations take the full N+1 cycles. Results SHALL be identical in both builds.

Verification
REQ-031 SHALL cover: XLEN=64, MUL rs1=7, rs2=-3 -> result=0xFFFFFFFFFFFFFFEB, out_valid 65 cycles after accept.
REQ-032 SHALL cover: MULHU rs1=rs2=0xFFFFFFFFFFFFFFFF -> result=0xFFFFFFFFFFFFFFFE; MULH same operands -> 0.
REQ-033 SHALL cover: DIV rs1=0x8000000000000000, rs2=-1 -> result=0x8000000000000000; REM same -> 0.
REQ-034 SHALL cover: DIVU rs1=5, rs2=0 -> result=all ones; REMU -> 5; with MULDIV_EARLY_OUT_EN out_valid 1 cycle after accept, else 65.
REQ-035 SHALL cover: DIVW rs1=0x00000000FFFFFFF9 (-7), rs2=2 -> result=0xFFFFFFFFFFFFFFFD, out_valid 33 cycles after accept.
REQ-036 SHALL cover: flush asserted 10 cycles into a DIV -> ready=1 next cycle, no out_valid; next request completes correctly.
